video_mixer_pipe: RTL and testbench
===================================

Name: video_mixer_pipe

Overview:
Parametrised successor to the arcade video output mixer. It takes native-depth RGB with raw syncs and blanking, and produces 6-bit-per-channel VGA with registered, aligned syncs. Additions over the current mixer:
- arbitrary input depth with bit replication
- weighted-luma monochrome mode
- blank forcing
- automatic HS/VS polarity detection and normalisation
- a fixed 2-cycle pipeline

It sits between the core's video generator (or scandoubler output) and the board VGA pins.

Parameters:
IN_BITS, 3, input colour width per channel, 1..6
HCNT_W, 12, width of clk_sys counters used for HS polarity detection
VCNT_W, 11, width of line counters used for VS polarity detection

Ports:
clk_sys  in  1  master clock; all logic on posedge
reset  in  1  synchronous, active-high
r_in  in  IN_BITS  red
g_in  in  IN_BITS  green
b_in  in  IN_BITS  blue
hs_in  in  1  horizontal sync, either polarity
vs_in  in  1  vertical sync, either polarity
blank  in  1  1 = blanking; forces black output
mono  in  1  1 = greyscale output
scanlines  in  2  00 none, 01 25%, 10 50%, 11 75% darkening
scan_phase  in  1  0 = darken odd lines, 1 = darken even lines
csync  in  1  1 = composite sync on VGA_HS, VGA_VS held 1
VGA_R  out  6  red
VGA_G  out  6  green
VGA_B  out  6  blue
VGA_HS  out  1  active-low hsync or csync
VGA_VS  out  1  active-low vsync
hs_pol  out  1  detected HS polarity, 1 = input active-low
vs_pol  out  1  detected VS polarity, 1 = input active-low

Behaviour:
- Clock/reset: one clock (clk_sys); reset synchronous active-high. Pipeline advances every clk_sys cycle; no clock enable.
- Reset values:
  - VGA_R/G/B = 0; VGA_HS = 1; VGA_VS = 1
  - hs_pol = vs_pol = 0
  - scanline flag = 0; all counters = 0
  - pipeline registers = 0 (sync stages = inactive)
- Reset asserted mid-frame: outputs return to reset values on the next edge. Polarity is re-learned from scratch.
- Expansion: each channel is replicated MSB-first to 6 bits, e.g. IN_BITS=3, 3'b101 -> 6'b101101. For IN_BITS=6 this is a pass-through. For IN_BITS=1 the bit is replicated 6 times.
- Mono: luma = (2R + 5G + B) >> 3 on the expanded 6-bit values.
  - Sum is computed in 9 bits, result is 6 bits; max input gives 63.
  - Luma drives all three channels.
- Normalised syncs:
  - hs_n = hs_in ^ hs_pol; vs_n = vs_in ^ vs_pol (active-high internally).
  - Both are delayed through the same 2 stages as colour.
- HS polarity detection:
  - hi_cnt counts clk_sys cycles with hs_in=1; lo_cnt counts cycles with hs_in=0. Both saturate at all-ones.
  - On each hs_in rising edge: hs_pol <= (hi_cnt > lo_cnt), then both counters clear.
  - Equal counts keep hs_pol unchanged.
- VS polarity detection: same algorithm using VCNT_W counters, but counting hs_n leading edges instead of clk_sys cycles, and updating on vs_in rising edges.
- Scanline flag:
  - Toggles on each hs_n rising edge; clears on each vs_n rising edge.
  - If both edges fall in the same cycle, the clear wins.
  - A line is darkened when (flag ^ scan_phase) = 1.
- Stage 1 (registered): expanded or mono colour, hs_n, vs_n, blank, darken.
- Stage 2 (registered):
  - blank=1 -> 0 on all channels.
  - Else, if darken, apply the mode: 01 -> (x>>1)+(x>>2); 10 -> x>>1; 11 -> x>>2. Otherwise pass through.
  - VGA_HS = csync ? ~(hs ^ vs) : ~hs.
  - VGA_VS = csync ? 1 : ~vs.
- Latency: input to VGA_* is exactly 2 clk_sys cycles for colour and sync alike. Changes on mono, scanlines and csync take effect with the same 2-cycle latency.
- Polarity changes apply to hs_n/vs_n from the cycle after the hs_pol/vs_pol update.

Test Plan:
1. IN_BITS=3, r=3'b101, g=3'b010, b=3'b111, mono=0, scanlines=00, blank=0 -> 2 cycles later VGA_R=45, VGA_G=18, VGA_B=63.
2. mono=1, r=g=b=3'b111 -> all channels 63. With r=7, g=0, b=0 -> all channels (2·63)>>3 = 15.
3. Active-high HS: 8 cycles high / 56 low per line, several lines -> hs_pol stays 0. Switch to active-low (56 high / 8 low) -> hs_pol=1 after the second rising edge, and VGA_HS low pulses are 8 cycles.
4. scanlines=01, scan_phase=0, constant colour 63 -> lines alternate 63 and 46 (31+15). Flag is 0 on the first line after each VS. scan_phase=1 inverts the pattern.
5. blank=1 with colour 63 -> outputs 0 after 2 cycles. csync=1 -> VGA_VS=1, and VGA_HS equals ~(hs^vs) delayed 2 cycles.
6. Assert reset mid-line with VGA_HS active -> next edge gives VGA_HS=1, VGA_VS=1, RGB=0, hs_pol=vs_pol=0. Polarity relearns within 2 lines/frames.

Source files
------------

// File: rtl/video_mixer_pipe.sv
`default_nettype none
// ============================================================================
// video_mixer_pipe : native-depth RGB + raw syncs -> 6-bit VGA, 2-cycle pipe
// Rev 1.0
// ============================================================================
module video_mixer_pipe #(
  parameter int IN_BITS = 3,
  parameter int HCNT_W  = 12,
  parameter int VCNT_W  = 11
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [IN_BITS-1:0] r_in,
  input  logic [IN_BITS-1:0] g_in,
  input  logic [IN_BITS-1:0] b_in,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               blank,
  input  logic               mono,
  input  logic [1:0]         scanlines,
  input  logic               scan_phase,
  input  logic               csync,
  output logic [5:0]         VGA_R,
  output logic [5:0]         VGA_G,
  output logic [5:0]         VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               hs_pol,
  output logic               vs_pol
);

  localparam logic [HCNT_W-1:0] c_hone = HCNT_W'(1);
  localparam logic [VCNT_W-1:0] c_vone = VCNT_W'(1);

  // MSB-first replication of an IN_BITS value into 6 bits
  function automatic logic [5:0] expand(input logic [IN_BITS-1:0] x);
    logic [5:0] e;
    for (int i = 0; i < 6; i++) e[5-i] = x[IN_BITS-1-(i%IN_BITS)];
    return e;
  endfunction

  function automatic logic [5:0] shade(input logic [5:0] x, input logic [1:0] m);
    case (m)
      2'b01:   shade = {1'b0, x[5:1]} + {2'b00, x[5:2]};
      2'b10:   shade = {1'b0, x[5:1]};
      2'b11:   shade = {2'b00, x[5:2]};
      default: shade = x;
    endcase
  endfunction

  logic [HCNT_W-1:0] r_hhi, r_hlo;
  logic [VCNT_W-1:0] r_vhi, r_vlo;
  logic              r_hs_d, r_vs_d, r_hsn_d, r_vsn_d, r_flag;
  logic [5:0]        r_s1_r, r_s1_g, r_s1_b;
  logic              r_s1_hs, r_s1_vs, r_s1_blank, r_s1_dark, r_s1_csync;
  logic [1:0]        r_s1_scan;

  logic       w_hs_n, w_vs_n, w_hs_rise, w_vs_rise, w_hsn_rise, w_vsn_rise;
  logic [5:0] w_r6, w_g6, w_b6, w_luma;
  logic [8:0] w_sum;

  assign w_hs_n     = hs_in ^ hs_pol;
  assign w_vs_n     = vs_in ^ vs_pol;
  assign w_hs_rise  = hs_in & ~r_hs_d;
  assign w_vs_rise  = vs_in & ~r_vs_d;
  assign w_hsn_rise = w_hs_n & ~r_hsn_d;
  assign w_vsn_rise = w_vs_n & ~r_vsn_d;

  assign w_r6   = expand(r_in);
  assign w_g6   = expand(g_in);
  assign w_b6   = expand(b_in);
  assign w_sum  = {2'b00, w_r6, 1'b0} + {3'b000, w_g6} * 9'd5 + {3'b000, w_b6};
  assign w_luma = w_sum[8:3];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hhi <= '0; r_hlo <= '0; r_vhi <= '0; r_vlo <= '0;
      r_hs_d <= 1'b0; r_vs_d <= 1'b0; r_hsn_d <= 1'b0; r_vsn_d <= 1'b0;
      r_flag <= 1'b0; hs_pol <= 1'b0; vs_pol <= 1'b0;
      r_s1_r <= '0; r_s1_g <= '0; r_s1_b <= '0;
      r_s1_hs <= 1'b0; r_s1_vs <= 1'b0; r_s1_blank <= 1'b0;
      r_s1_dark <= 1'b0; r_s1_csync <= 1'b0; r_s1_scan <= 2'b00;
      VGA_R <= '0; VGA_G <= '0; VGA_B <= '0;
      VGA_HS <= 1'b1; VGA_VS <= 1'b1;
    end else begin
      r_hs_d  <= hs_in;
      r_vs_d  <= vs_in;
      r_hsn_d <= w_hs_n;
      r_vsn_d <= w_vs_n;

      // Longer phase of the line is the inactive level; ties keep old polarity
      if (w_hs_rise) begin
        if (r_hhi > r_hlo)      hs_pol <= 1'b1;
        else if (r_hlo > r_hhi) hs_pol <= 1'b0;
        r_hhi <= '0;
        r_hlo <= '0;
      end else if (hs_in) begin
        if (r_hhi != '1) r_hhi <= r_hhi + c_hone;
      end else begin
        if (r_hlo != '1) r_hlo <= r_hlo + c_hone;
      end

      if (w_vs_rise) begin
        if (r_vhi > r_vlo)      vs_pol <= 1'b1;
        else if (r_vlo > r_vhi) vs_pol <= 1'b0;
        r_vhi <= '0;
        r_vlo <= '0;
      end else if (w_hsn_rise) begin
        if (vs_in) begin
          if (r_vhi != '1) r_vhi <= r_vhi + c_vone;
        end else begin
          if (r_vlo != '1) r_vlo <= r_vlo + c_vone;
        end
      end

      if (w_vsn_rise)      r_flag <= 1'b0;
      else if (w_hsn_rise) r_flag <= ~r_flag;

      r_s1_r     <= mono ? w_luma : w_r6;
      r_s1_g     <= mono ? w_luma : w_g6;
      r_s1_b     <= mono ? w_luma : w_b6;
      r_s1_hs    <= w_hs_n;
      r_s1_vs    <= w_vs_n;
      r_s1_blank <= blank;
      r_s1_dark  <= r_flag ^ scan_phase;
      r_s1_scan  <= scanlines;
      r_s1_csync <= csync;

      VGA_R  <= r_s1_blank ? 6'd0 : (r_s1_dark ? shade(r_s1_r, r_s1_scan) : r_s1_r);
      VGA_G  <= r_s1_blank ? 6'd0 : (r_s1_dark ? shade(r_s1_g, r_s1_scan) : r_s1_g);
      VGA_B  <= r_s1_blank ? 6'd0 : (r_s1_dark ? shade(r_s1_b, r_s1_scan) : r_s1_b);
      VGA_HS <= r_s1_csync ? ~(r_s1_hs ^ r_s1_vs) : ~r_s1_hs;
      VGA_VS <= r_s1_csync ? 1'b1 : ~r_s1_vs;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_mixer_pipe.sv
`default_nettype none
// ============================================================================
// tb_video_mixer_pipe : randomized bench against a cycle-level reference model
// Rev 1.0
// ============================================================================
module tb_video_mixer_pipe;

  localparam int IN_BITS = 3;
  localparam int HCNT_W  = 12;
  localparam int VCNT_W  = 11;
  localparam int HMAX    = (1 << HCNT_W) - 1;
  localparam int VMAX    = (1 << VCNT_W) - 1;
  localparam logic [19:0] RESET20 = {18'd0, 1'b1, 1'b1};

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic               reset = 1'b1;
  logic [IN_BITS-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic               hs_in = 1'b0, vs_in = 1'b0, blank = 1'b0, mono = 1'b0;
  logic [1:0]         scanlines = 2'b00;
  logic               scan_phase = 1'b0, csync = 1'b0;
  logic [5:0]         VGA_R, VGA_G, VGA_B;
  logic               VGA_HS, VGA_VS, hs_pol, vs_pol;

  video_mixer_pipe #(.IN_BITS(IN_BITS), .HCNT_W(HCNT_W), .VCNT_W(VCNT_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .blank(blank), .mono(mono),
    .scanlines(scanlines), .scan_phase(scan_phase), .csync(csync),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .hs_pol(hs_pol), .vs_pol(vs_pol)
  );

  logic [21:0] dut_vec;
  assign dut_vec = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, hs_pol, vs_pol};

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  bit m_hpol, m_vpol, m_flag, m_hs_prev, m_vs_prev, m_hsn_prev, m_vsn_prev;
  int m_hhi, m_hlo, m_vhi, m_vlo;
  logic [19:0] exp20, prev20;
  logic [21:0] expv;

  // Sync generator position
  int pix, ln;

  function automatic int expand6(input int x);
    longint acc = 0;
    for (int k = 0; k < 6; k++) acc = acc * (64'd1 << IN_BITS) + longint'(x);
    return int'(acc >> (6 * IN_BITS - 6));
  endfunction

  function automatic int dim(input int x, input int mode);
    case (mode)
      1:       return x / 2 + x / 4;
      2:       return x / 2;
      3:       return x / 4;
      default: return x;
    endcase
  endfunction

  function automatic logic [19:0] model_out();
    int r, g, b, y;
    bit hsn, vsn, hso, vso;
    r = expand6(int'(r_in)); g = expand6(int'(g_in)); b = expand6(int'(b_in));
    if (mono) begin
      y = (2 * r + 5 * g + b) / 8;
      r = y; g = y; b = y;
    end
    if (blank) begin
      r = 0; g = 0; b = 0;
    end else if (m_flag ^ scan_phase) begin
      r = dim(r, int'(scanlines)); g = dim(g, int'(scanlines)); b = dim(b, int'(scanlines));
    end
    hsn = hs_in ^ m_hpol;
    vsn = vs_in ^ m_vpol;
    hso = csync ? !(hsn ^ vsn) : !hsn;
    vso = csync ? 1'b1 : !vsn;
    return {6'(r), 6'(g), 6'(b), hso, vso};
  endfunction

  // Advance one clock: update the model from the inputs now applied, then clock
  task automatic step();
    bit hsn, vsn, hrise, vrise, hnr, vnr;
    if (reset) begin
      m_hpol = 0; m_vpol = 0; m_flag = 0;
      m_hs_prev = 0; m_vs_prev = 0; m_hsn_prev = 0; m_vsn_prev = 0;
      m_hhi = 0; m_hlo = 0; m_vhi = 0; m_vlo = 0;
      exp20 = RESET20; prev20 = RESET20;
    end else begin
      exp20  = prev20;
      prev20 = model_out();
      hsn = hs_in ^ m_hpol;  vsn = vs_in ^ m_vpol;
      hrise = hs_in && !m_hs_prev;  vrise = vs_in && !m_vs_prev;
      hnr = hsn && !m_hsn_prev;  vnr = vsn && !m_vsn_prev;
      if (hrise) begin
        if (m_hhi > m_hlo) m_hpol = 1; else if (m_hlo > m_hhi) m_hpol = 0;
        m_hhi = 0; m_hlo = 0;
      end else if (hs_in) m_hhi = (m_hhi < HMAX) ? m_hhi + 1 : HMAX;
      else                m_hlo = (m_hlo < HMAX) ? m_hlo + 1 : HMAX;
      if (vrise) begin
        if (m_vhi > m_vlo) m_vpol = 1; else if (m_vlo > m_vhi) m_vpol = 0;
        m_vhi = 0; m_vlo = 0;
      end else if (hnr) begin
        if (vs_in) m_vhi = (m_vhi < VMAX) ? m_vhi + 1 : VMAX;
        else       m_vlo = (m_vlo < VMAX) ? m_vlo + 1 : VMAX;
      end
      if (vnr) m_flag = 0; else if (hnr) m_flag = !m_flag;
      m_hs_prev = hs_in; m_vs_prev = vs_in; m_hsn_prev = hsn; m_vsn_prev = vsn;
    end
    expv = {exp20, m_hpol, m_vpol};
    @(posedge clk_sys);
    #1;
  endtask

  // Drive syncs for the current position, then advance position
  task automatic sync_gen(input int hlen, input int line_len, input bit hlow,
                          input int vlen, input int frame, input bit vlow);
    hs_in = (pix < hlen) ^ hlow;
    vs_in = (ln < vlen) ^ vlow;
    pix++;
    if (pix == line_len) begin
      pix = 0;
      ln  = (ln + 1 == frame) ? 0 : ln + 1;
    end
  endtask

  task automatic rand_colour();
    r_in = IN_BITS'($urandom); g_in = IN_BITS'($urandom); b_in = IN_BITS'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (dut_vec !== 22'({18'd0, 1'b1, 1'b1, 1'b0, 1'b0})) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 22'({18'd0, 4'b1100}));
    end
    reset = 1'b0;
  endtask

  task automatic test_expand();
    r_in = 3'b101; g_in = 3'b010; b_in = 3'b111;
    hs_in = 0; vs_in = 0; mono = 0; scanlines = 0; blank = 0; csync = 0;
    for (int i = 0; i < 3; i++) begin
      step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL expand_fixed got=%h exp=%h", dut_vec, expv); end
    end
    vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== {6'd45, 6'd18, 6'd63}) begin
      errors++; $display("FAIL expand_101 got=%0d/%0d/%0d exp=45/18/63", VGA_R, VGA_G, VGA_B);
    end
    for (int i = 0; i < 40; i++) begin
      rand_colour(); step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL expand_rand got=%h exp=%h", dut_vec, expv); end
    end
  endtask

  task automatic test_mono();
    mono = 1; r_in = 3'b111; g_in = 3'b111; b_in = 3'b111;
    step(); step(); step(); vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== {3{6'd63}}) begin
      errors++; $display("FAIL mono_white got=%0d/%0d/%0d exp=63", VGA_R, VGA_G, VGA_B);
    end
    r_in = 3'd7; g_in = 3'd0; b_in = 3'd0;
    step(); step(); step(); vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== {3{6'd15}}) begin
      errors++; $display("FAIL mono_red got=%0d/%0d/%0d exp=15", VGA_R, VGA_G, VGA_B);
    end
    for (int i = 0; i < 40; i++) begin
      rand_colour(); mono = 1'($urandom); step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL mono_rand got=%h exp=%h", dut_vec, expv); end
    end
    mono = 0;
  endtask

  task automatic test_hs_polarity();
    int lows;
    pix = 0; ln = 0;
    for (int i = 0; i < 64 * 12; i++) begin
      sync_gen(8, 64, 0, 2, 10, 0); rand_colour(); step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL hs_active_high got=%h exp=%h", dut_vec, expv); end
    end
    vectors++;
    if (hs_pol !== 1'b0) begin errors++; $display("FAIL hs_pol_high got=%b exp=0", hs_pol); end
    for (int i = 0; i < 64 * 4; i++) begin
      sync_gen(8, 64, 1, 2, 10, 0); rand_colour(); step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL hs_active_low got=%h exp=%h", dut_vec, expv); end
    end
    vectors++;
    if (hs_pol !== 1'b1) begin errors++; $display("FAIL hs_pol_low got=%b exp=1", hs_pol); end
    lows = 0;
    for (int i = 0; i < 64; i++) begin
      sync_gen(8, 64, 1, 2, 10, 0); step();
      if (VGA_HS === 1'b0) lows++;
    end
    vectors++;
    if (lows != 8) begin errors++; $display("FAIL hs_pulse_width got=%0d exp=8", lows); end
  endtask

  task automatic test_scanlines();
    r_in = 3'b111; g_in = 3'b111; b_in = 3'b111;
    for (int m = 1; m < 4; m++) begin
      for (int ph = 0; ph < 2; ph++) begin
        scanlines = 2'(m); scan_phase = 1'(ph);
        for (int i = 0; i < 64 * 12; i++) begin
          sync_gen(8, 64, 1, 2, 10, 0); step(); vectors++;
          if (dut_vec !== expv) begin
            errors++; $display("FAIL scanline_m%0d_p%0d got=%h exp=%h", m, ph, dut_vec, expv);
          end
        end
      end
    end
  endtask

  task automatic test_blank_csync();
    blank = 1; r_in = 3'b111; g_in = 3'b111; b_in = 3'b111; scanlines = 0;
    step(); step(); step(); vectors++;
    if ({VGA_R, VGA_G, VGA_B} !== 18'd0) begin
      errors++; $display("FAIL blank_force got=%0d/%0d/%0d exp=0", VGA_R, VGA_G, VGA_B);
    end
    blank = 0; csync = 1;
    for (int i = 0; i < 64 * 10; i++) begin
      sync_gen(8, 64, 1, 2, 10, 0); rand_colour();
      blank = 1'($urandom); mono = 1'($urandom);
      scanlines = 2'($urandom); scan_phase = 1'($urandom);
      step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL csync_mix got=%h exp=%h", dut_vec, expv); end
    end
    vectors++;
    if (VGA_VS !== 1'b1) begin errors++; $display("FAIL csync_vs got=%b exp=1", VGA_VS); end
    csync = 0; blank = 0; mono = 0; scanlines = 0;
  endtask

  task automatic test_reset_mid();
    pix = 0; ln = 0;
    for (int i = 0; i < 64 * 30; i++) begin
      sync_gen(8, 64, 1, 2, 10, 1); rand_colour(); step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL pre_reset got=%h exp=%h", dut_vec, expv); end
    end
    for (int i = 0; i < 200 && pix != 4; i++) begin
      sync_gen(8, 64, 1, 2, 10, 1); step();
    end
    vectors++;
    if (dut_vec !== expv) begin errors++; $display("FAIL hs_active_before_reset got=%h exp=%h", dut_vec, expv); end
    reset = 1; sync_gen(8, 64, 1, 2, 10, 1); step(); vectors++;
    if (dut_vec !== 22'({18'd0, 4'b1100})) begin
      errors++; $display("FAIL mid_reset got=%h exp=%h", dut_vec, 22'({18'd0, 4'b1100}));
    end
    reset = 0;
    for (int i = 0; i < 64 * 30; i++) begin
      sync_gen(8, 64, 1, 2, 10, 1); rand_colour(); step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL relearn got=%h exp=%h", dut_vec, expv); end
    end
    vectors++;
    if ({hs_pol, vs_pol} !== 2'b11) begin errors++; $display("FAIL relearn_pol got=%b exp=11", {hs_pol, vs_pol}); end
  endtask

  task automatic test_random();
    bit hl, vl;
    hl = 1'($urandom); vl = 1'($urandom);
    pix = 0; ln = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 0) begin hl = 1'($urandom); vl = 1'($urandom); end
      sync_gen(4, 32, hl, 1, 8, vl); rand_colour();
      blank = ($urandom_range(0, 7) == 0); mono = 1'($urandom);
      scanlines = 2'($urandom); scan_phase = 1'($urandom); csync = 1'($urandom);
      step(); vectors++;
      if (dut_vec !== expv) begin errors++; $display("FAIL random got=%h exp=%h", dut_vec, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_expand();
    test_mono();
    test_hs_polarity();
    test_scanlines();
    test_blank_csync();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
